// File: rtl/data_cache_if.sv
// CPU-side and memory-side signal bundle for the direct-mapped data cache.
// The cache is the slave; the CPU/memory environment is the master.
interface data_cache_if;
  logic        READ;
  logic        WRITE;
  logic [7:0]  ADDRESS;
  logic [7:0]  WRITEDATA;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  modport slave (
    input  READ, WRITE, ADDRESS, WRITEDATA,
    input  MEM_READDATA, MEM_BUSYWAIT,
    output READDATA, BUSYWAIT,
    output MEM_READ, MEM_WRITE,
    output MEM_ADDRESS, MEM_WRITEDATA
  );

  modport master (
    output READ, WRITE, ADDRESS, WRITEDATA,
    output MEM_READDATA, MEM_BUSYWAIT,
    input  READDATA, BUSYWAIT,
    input  MEM_READ, MEM_WRITE,
    input  MEM_ADDRESS, MEM_WRITEDATA
  );
endinterface

// File: rtl/data_cache.sv
// 8 x 4-byte direct-mapped write-back, write-allocate data cache.
// CPU request is held stable by the CPU while BUSYWAIT is high.
module data_cache (
  input  logic       CLK,
  input  logic       RESET,
  data_cache_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    WB,
    FETCH,
    FILL
  } state_e;

  state_e      state_q;
  logic [7:0]  valid_q;
  logic [7:0]  dirty_q;
  logic [2:0]  tag_q  [8];
  logic [31:0] data_q [8];
  logic [31:0] fill_q;

  logic [2:0]  idx;
  logic [2:0]  tag;
  logic [1:0]  off;
  logic [31:0] blk;
  logic [31:0] wblk;
  logic        hit;
  logic        req;
  logic        miss;

  assign tag  = bus.ADDRESS[7:5];
  assign idx  = bus.ADDRESS[4:2];
  assign off  = bus.ADDRESS[1:0];
  assign blk  = data_q[idx];
  assign hit  = valid_q[idx] && (tag_q[idx] == tag);
  assign req  = bus.READ || bus.WRITE;
  assign miss = req && !hit;

  always_comb begin
    wblk = blk;
    wblk[{off, 3'b000} +: 8] = bus.WRITEDATA;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.WRITE && hit) begin
            data_q[idx]  <= wblk;
            dirty_q[idx] <= 1'b1;
          end else if (miss) begin
            state_q <= (valid_q[idx] && dirty_q[idx]) ? WB : FETCH;
          end
        end
        WB: begin
          if (!bus.MEM_BUSYWAIT) state_q <= FETCH;
        end
        FETCH: begin
          if (!bus.MEM_BUSYWAIT) begin
            fill_q  <= bus.MEM_READDATA;
            state_q <= FILL;
          end
        end
        FILL: begin
          data_q[idx]  <= fill_q;
          tag_q[idx]   <= tag;
          valid_q[idx] <= 1'b1;
          dirty_q[idx] <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory strobes depend on state only; the miss stall is combinational.
  assign bus.MEM_READ      = (state_q == FETCH);
  assign bus.MEM_WRITE     = (state_q == WB);
  assign bus.MEM_ADDRESS   = (state_q == WB) ? {tag_q[idx], idx}
                                             : {tag, idx};
  assign bus.MEM_WRITEDATA = blk;
  assign bus.BUSYWAIT      = (state_q != IDLE) || miss;
  assign bus.READDATA      = blk[{off, 3'b000} +: 8];
endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: memory responder, flat byte-memory reference
// model, directed scenarios and a randomized access sweep.
module tb_data_cache;
  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  data_cache_if bus();

  data_cache dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] tb_mem [64];
  int          stall_wb = 0;
  int          stall_fetch = 0;
  int          act_cnt = 0;
  int          wb_count = 0;
  logic [5:0]  wb_addr;
  logic [31:0] wb_data;
  logic [5:0]  fetch_addr;
  int          busy_cnt = 0;
  bit          run = 0;

  // Backing memory with a programmable number of stall cycles per request
  always @(negedge CLK) begin
    if (bus.MEM_READ || bus.MEM_WRITE) begin
      act_cnt++;
      if (!run) begin
        run = 1;
        busy_cnt = bus.MEM_WRITE ? stall_wb : stall_fetch;
        if (bus.MEM_READ) fetch_addr = bus.MEM_ADDRESS;
      end
      if (busy_cnt > 0) begin
        bus.MEM_BUSYWAIT = 1'b1;
        busy_cnt--;
      end else begin
        bus.MEM_BUSYWAIT = 1'b0;
        run = 0;
        if (bus.MEM_WRITE) begin
          tb_mem[bus.MEM_ADDRESS] = bus.MEM_WRITEDATA;
          wb_addr = bus.MEM_ADDRESS;
          wb_data = bus.MEM_WRITEDATA;
          wb_count++;
        end else begin
          bus.MEM_READDATA = tb_mem[bus.MEM_ADDRESS];
        end
      end
    end else begin
      bus.MEM_BUSYWAIT = 1'b0;
      run = 0;
    end
  end

  // Reference: architectural byte memory plus which lines the cache holds
  logic [7:0] ref_mem [256];
  bit         m_valid [8];
  bit         m_dirty [8];
  logic [2:0] m_tag   [8];

  function automatic void ref_sync();
    for (int i = 0; i < 64; i++)
      for (int b = 0; b < 4; b++)
        ref_mem[{i[5:0], b[1:0]}] = tb_mem[i][8*b +: 8];
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
  endfunction

  function automatic void ref_step(
    input  bit          w,
    input  logic [7:0]  a,
    input  logic [7:0]  d,
    input  int          sw,
    input  int          sf,
    output int          lat,
    output bit          wb,
    output logic [5:0]  wba,
    output logic [31:0] wbd,
    output logic [7:0]  rd
  );
    logic [2:0] i;
    logic [2:0] t;
    i   = a[4:2];
    t   = a[7:5];
    lat = 0;
    wb  = 0;
    wba = '0;
    wbd = '0;
    if (!(m_valid[i] && m_tag[i] == t)) begin
      if (m_valid[i] && m_dirty[i]) begin
        wb  = 1;
        wba = {m_tag[i], i};
        wbd = {ref_mem[{wba, 2'd3}], ref_mem[{wba, 2'd2}],
               ref_mem[{wba, 2'd1}], ref_mem[{wba, 2'd0}]};
        lat = sw + 1;
      end
      lat += sf + 3;
      m_valid[i] = 1;
      m_tag[i]   = t;
      m_dirty[i] = 0;
    end
    if (w) begin
      ref_mem[a] = d;
      m_dirty[i] = 1;
    end
    rd = ref_mem[a];
  endfunction

  task automatic access(
    input  logic       r,
    input  logic       w,
    input  logic [7:0] a,
    input  logic [7:0] d,
    output int         lat,
    output logic [7:0] rd
  );
    bus.READ = r;
    bus.WRITE = w;
    bus.ADDRESS = a;
    bus.WRITEDATA = d;
    #1;
    lat = 0;
    while (bus.BUSYWAIT !== 1'b0 && lat < 500) begin
      @(posedge CLK);
      #1;
      lat++;
    end
    rd = bus.READDATA;
    @(posedge CLK);
    #1;
    bus.READ = 1'b0;
    bus.WRITE = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    bus.READ = 1'b0;
    bus.WRITE = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    ref_sync();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (bus.BUSYWAIT !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_busywait got %b want 0", bus.BUSYWAIT);
    end
    n_cmp++;
    if (bus.MEM_READ !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mem_read got %b want 0", bus.MEM_READ);
    end
    n_cmp++;
    if (bus.MEM_WRITE !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mem_write got %b want 0", bus.MEM_WRITE);
    end
  endtask

  task automatic test_clean_miss();
    int lat, elat, w0;
    bit wb;
    logic [5:0] wba;
    logic [31:0] wbd;
    logic [7:0] rd, erd;
    stall_fetch = 5;
    w0 = wb_count;
    ref_step(0, 8'h05, 8'h00, 0, 5, elat, wb, wba, wbd, erd);
    access(1, 0, 8'h05, 8'h00, lat, rd);
    n_cmp++;
    if (lat !== 8) begin
      n_bad++;
      $display("FAIL clean_miss_latency got %0d want 8", lat);
    end
    n_cmp++;
    if (fetch_addr !== 6'h01) begin
      n_bad++;
      $display("FAIL clean_miss_fetch_addr got %h want 01", fetch_addr);
    end
    n_cmp++;
    if (rd !== 8'h22) begin
      n_bad++;
      $display("FAIL clean_miss_data got %h want 22", rd);
    end
    n_cmp++;
    if (wb_count !== w0) begin
      n_bad++;
      $display("FAIL clean_miss_no_wb got %0d want %0d", wb_count, w0);
    end
  endtask

  task automatic test_write_hit();
    int lat, elat, a0;
    bit wb;
    logic [5:0] wba;
    logic [31:0] wbd;
    logic [7:0] rd, erd;
    a0 = act_cnt;
    ref_step(1, 8'h06, 8'hAB, 0, 0, elat, wb, wba, wbd, erd);
    access(0, 1, 8'h06, 8'hAB, lat, rd);
    n_cmp++;
    if (lat !== 0) begin
      n_bad++;
      $display("FAIL write_hit_stall got %0d want 0", lat);
    end
    ref_step(0, 8'h06, 8'h00, 0, 0, elat, wb, wba, wbd, erd);
    access(1, 0, 8'h06, 8'h00, lat, rd);
    n_cmp++;
    if (rd !== 8'hAB) begin
      n_bad++;
      $display("FAIL write_hit_readback got %h want ab", rd);
    end
    n_cmp++;
    if (act_cnt !== a0) begin
      n_bad++;
      $display("FAIL write_hit_mem_idle got %0d want %0d", act_cnt, a0);
    end
  endtask

  task automatic test_dirty_evict();
    int lat, elat, w0;
    bit wb;
    logic [5:0] wba;
    logic [31:0] wbd;
    logic [7:0] rd, erd;
    stall_wb = 2;
    stall_fetch = 1;
    w0 = wb_count;
    ref_step(0, 8'h25, 8'h00, 2, 1, elat, wb, wba, wbd, erd);
    access(1, 0, 8'h25, 8'h00, lat, rd);
    n_cmp++;
    if (wb_count !== w0 + 1) begin
      n_bad++;
      $display("FAIL evict_wb_count got %0d want %0d", wb_count, w0 + 1);
    end
    n_cmp++;
    if (wb_addr !== 6'h01) begin
      n_bad++;
      $display("FAIL evict_wb_addr got %h want 01", wb_addr);
    end
    n_cmp++;
    if (wb_data !== 32'h44AB2211) begin
      n_bad++;
      $display("FAIL evict_wb_data got %h want 44ab2211", wb_data);
    end
    n_cmp++;
    if (fetch_addr !== 6'h09) begin
      n_bad++;
      $display("FAIL evict_fetch_addr got %h want 09", fetch_addr);
    end
    n_cmp++;
    if (lat !== 7) begin
      n_bad++;
      $display("FAIL evict_latency got %0d want 7", lat);
    end
    n_cmp++;
    if (rd !== erd) begin
      n_bad++;
      $display("FAIL evict_data got %h want %h", rd, erd);
    end
    w0 = wb_count;
    ref_step(0, 8'h05, 8'h00, 2, 1, elat, wb, wba, wbd, erd);
    access(1, 0, 8'h05, 8'h00, lat, rd);
    n_cmp++;
    if (wb_count !== w0) begin
      n_bad++;
      $display("FAIL filled_line_clean got %0d want %0d", wb_count, w0);
    end
    n_cmp++;
    if (rd !== 8'h22) begin
      n_bad++;
      $display("FAIL refetch_data got %h want 22", rd);
    end
  endtask

  task automatic test_idle();
    int a0, lat;
    logic [7:0] rd;
    a0 = act_cnt;
    for (int c = 0; c < 10; c++) begin
      @(posedge CLK);
      #1;
      n_cmp++;
      if ({bus.BUSYWAIT, bus.MEM_READ, bus.MEM_WRITE} !== 3'b000) begin
        n_bad++;
        $display("FAIL idle_outputs cycle %0d got %b want 000", c,
                 {bus.BUSYWAIT, bus.MEM_READ, bus.MEM_WRITE});
      end
    end
    n_cmp++;
    if (act_cnt !== a0) begin
      n_bad++;
      $display("FAIL idle_mem_activity got %0d want %0d", act_cnt, a0);
    end
    access(1, 0, 8'h06, 8'h00, lat, rd);
    n_cmp++;
    if (lat !== 0 || rd !== ref_mem[8'h06]) begin
      n_bad++;
      $display("FAIL idle_array_kept got lat %0d data %h want 0 %h",
               lat, rd, ref_mem[8'h06]);
    end
  endtask

  task automatic test_both_high();
    int lat, elat, w0;
    bit wb;
    logic [5:0] wba;
    logic [31:0] wbd;
    logic [7:0] rd, erd;
    ref_step(1, 8'h06, 8'h5C, 0, 0, elat, wb, wba, wbd, erd);
    access(1, 1, 8'h06, 8'h5C, lat, rd);
    n_cmp++;
    if (lat !== 0) begin
      n_bad++;
      $display("FAIL both_high_stall got %0d want 0", lat);
    end
    ref_step(0, 8'h06, 8'h00, 0, 0, elat, wb, wba, wbd, erd);
    access(1, 0, 8'h06, 8'h00, lat, rd);
    n_cmp++;
    if (rd !== 8'h5C) begin
      n_bad++;
      $display("FAIL both_high_readback got %h want 5c", rd);
    end
    stall_wb = 0;
    stall_fetch = 0;
    w0 = wb_count;
    ref_step(0, 8'h26, 8'h00, 0, 0, elat, wb, wba, wbd, erd);
    access(1, 0, 8'h26, 8'h00, lat, rd);
    n_cmp++;
    if (wb_count !== w0 + 1 || wb_data[23:16] !== 8'h5C) begin
      n_bad++;
      $display("FAIL both_high_dirty got wbs %0d byte %h want %0d 5c",
               wb_count - w0, wb_data[23:16], 1);
    end
  endtask

  task automatic test_reset_mid_fetch();
    int lat, elat;
    bit wb;
    logic [5:0] wba;
    logic [31:0] wbd;
    logic [7:0] rd, erd;
    stall_fetch = 10;
    bus.READ = 1'b1;
    bus.ADDRESS = 8'h05;
    @(posedge CLK);
    #1;
    n_cmp++;
    if (bus.MEM_READ !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_fetch_entered got %b want 1", bus.MEM_READ);
    end
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    n_cmp++;
    if ({bus.MEM_READ, bus.MEM_WRITE} !== 2'b00) begin
      n_bad++;
      $display("FAIL mid_fetch_abandon got %b want 00",
               {bus.MEM_READ, bus.MEM_WRITE});
    end
    bus.READ = 1'b0;
    ref_sync();
    stall_fetch = 2;
    ref_step(0, 8'h05, 8'h00, 0, 2, elat, wb, wba, wbd, erd);
    access(1, 0, 8'h05, 8'h00, lat, rd);
    n_cmp++;
    if (lat !== 5) begin
      n_bad++;
      $display("FAIL post_reset_miss got %0d want 5", lat);
    end
    n_cmp++;
    if (rd !== erd) begin
      n_bad++;
      $display("FAIL post_reset_data got %h want %h", rd, erd);
    end
  endtask

  task automatic test_random();
    int lat, elat, w0, op, sw, sf;
    bit wb;
    logic [5:0] wba;
    logic [31:0] wbd;
    logic [7:0] rd, erd, a, d;
    logic r, w;
    for (int k = 0; k < 200; k++) begin
      a  = {3'($urandom_range(0, 3)), 5'($urandom_range(0, 31))};
      d  = 8'($urandom);
      op = $urandom_range(0, 2);
      r  = (op != 1);
      w  = (op != 0);
      sw = $urandom_range(0, 3);
      sf = $urandom_range(0, 3);
      stall_wb = sw;
      stall_fetch = sf;
      w0 = wb_count;
      ref_step(w, a, d, sw, sf, elat, wb, wba, wbd, erd);
      access(r, w, a, d, lat, rd);
      n_cmp++;
      if (lat !== elat) begin
        n_bad++;
        $display("FAIL rand_latency[%0d] a=%h got %0d want %0d",
                 k, a, lat, elat);
      end
      n_cmp++;
      if (wb_count - w0 !== int'(wb)) begin
        n_bad++;
        $display("FAIL rand_wb_flag[%0d] a=%h got %0d want %0d",
                 k, a, wb_count - w0, wb);
      end
      if (wb) begin
        n_cmp++;
        if (wb_addr !== wba || wb_data !== wbd) begin
          n_bad++;
          $display("FAIL rand_wb[%0d] got %h/%h want %h/%h",
                   k, wb_addr, wb_data, wba, wbd);
        end
      end
      if (!w) begin
        n_cmp++;
        if (rd !== erd) begin
          n_bad++;
          $display("FAIL rand_read[%0d] a=%h got %h want %h",
                   k, a, rd, erd);
        end
      end
    end
  endtask

  initial begin
    RESET = 1'b1;
    bus.READ = 1'b0;
    bus.WRITE = 1'b0;
    bus.ADDRESS = 8'h00;
    bus.WRITEDATA = 8'h00;
    for (int i = 0; i < 64; i++) tb_mem[i] = $urandom;
    tb_mem[1] = 32'h44332211;
    test_reset();
    test_clean_miss();
    test_write_hit();
    test_dirty_evict();
    test_idle();
    test_both_high();
    test_reset_mid_fetch();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 SHALL have no parameters; geometry fixed: 8 blocks x 4 bytes, direct-mapped, write-back, write-allocate.
REQ-002 SHALL use clock CLK and reset RESET: synchronous, active-high.
REQ-003 Ports SHALL be:
- CLK  input  1  clock
- RESET  input  1  synchronous active-high reset
- READ  input  1  CPU load request
- WRITE  input  1  CPU store request
- ADDRESS  input  8  CPU byte address: [7:5] tag, [4:2] index, [1:0] byte offset
- WRITEDATA  input  8  CPU store byte
- READDATA  output  8  CPU load byte
- BUSYWAIT  output  1  stall to CPU
- MEM_READ  output  1  block fetch request
- MEM_WRITE  output  1  block write-back request
- MEM_ADDRESS  output  6  block address {tag, index}
- MEM_WRITEDATA  output  32  write-back block
- MEM_READDATA  input  32  fetched block
- MEM_BUSYWAIT  input  1  memory stall

Function
REQ-004 Per block SHALL store: valid bit, dirty bit, 3-bit tag, 32-bit data; byte n = data[8n+7:8n].
REQ-005 hit SHALL = valid[index] AND tag[index] == ADDRESS[7:5] (combinational).
REQ-006 FSM states SHALL be IDLE, WB (write-back), FETCH, FILL.
REQ-007 IDLE, request active, hit:
- read: READDATA = selected byte, combinational.
- write: byte written and dirty set at next posedge.
- BUSYWAIT = 0.
REQ-008 IDLE, request active, miss: BUSYWAIT = 1 combinationally; next state WB if valid AND dirty, else FETCH.
REQ-009 WB SHALL drive MEM_WRITE = 1, MEM_ADDRESS = {stored tag, index}, MEM_WRITEDATA = stored block. It SHALL move to FETCH at the first posedge with MEM_BUSYWAIT = 0.
REQ-010 FETCH SHALL drive MEM_READ = 1 and MEM_ADDRESS = {ADDRESS[7:5], index}. It SHALL move to FILL at the first posedge with MEM_BUSYWAIT = 0, capturing MEM_READDATA at that posedge.
REQ-011 FILL SHALL write the captured block, tag = ADDRESS[7:5], valid = 1, dirty = 0, and return to IDLE after exactly one cycle. The request then completes as a hit per REQ-007.
REQ-012 BUSYWAIT SHALL be 1 in WB, FETCH and FILL. MEM_READ and MEM_WRITE SHALL be 0 outside FETCH and WB respectively; both SHALL be decoded from state only.
REQ-013 No request (READ = WRITE = 0) in IDLE: BUSYWAIT = 0, no array update, state held.
REQ-014 READ and WRITE both high SHALL be treated as WRITE.
REQ-015 ADDRESS, WRITEDATA, READ and WRITE SHALL be held stable by the CPU while BUSYWAIT = 1; the block need not register them.
REQ-016 Miss latency SHALL be (clean): 1 FETCH cycle + memory wait + 1 FILL cycle before BUSYWAIT falls. Dirty misses add 1 WB cycle + memory wait.
REQ-017 READDATA SHALL be don't-care when READ = 0.

Reset
REQ-018 At a posedge with RESET = 1: state = IDLE; all valid and dirty bits = 0; tags and data unchanged.
REQ-019 Outputs after reset SHALL be: MEM_READ = 0, MEM_WRITE = 0, BUSYWAIT = 0 when no request.
REQ-020 RESET SHALL override all state transitions, including mid-WB or mid-FETCH; the outstanding memory request is abandoned.

Verification
REQ-021 After reset, read 0x05:
- FETCH with MEM_ADDRESS = 0x01.
- Memory returns 0x44332211 after 5 stall cycles.
- FILL, then READDATA = 0x22 and BUSYWAIT = 0.
REQ-022 Then write 0xAB to 0x06: no BUSYWAIT, no MEM_* activity; a following read of 0x06 returns 0xAB.
REQ-023 Then read 0x25:
- WB with MEM_ADDRESS = 0x01, MEM_WRITEDATA = 0x44AB2211.
- Then FETCH with MEM_ADDRESS = 0x09.
- Block marked clean after FILL.
REQ-024 RESET pulsed during FETCH: next cycle MEM_READ = 0, state IDLE. A subsequent read of 0x05 misses again (valid cleared).
REQ-025 READ = WRITE = 0 for 10 cycles: BUSYWAIT, MEM_READ and MEM_WRITE stay 0; arrays unchanged.
REQ-026 READ and WRITE both high on a hit to 0x06 with WRITEDATA = 0x5C: byte stored, dirty set, and a subsequent read returns 0x5C.
